// File: rtl/tblreq_arbiter.sv
// Round-robin arbiter sharing one MAC-to-port lookup table among NREQ requesters.
// Optional table-response timeout with broadcast fallback: define TBLREQ_ARBITER_TIMEOUT_EN.
module tblreq_arbiter #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned NETH    = 4,
    parameter int unsigned MACW    = 48,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [NREQ-1:0]      S_REQUEST,
    input  logic [NREQ*MACW-1:0] S_MAC,
    output logic [NREQ-1:0]      S_VALID,
    output logic [NETH-1:0]      S_PORT,
    output logic                 M_REQUEST,
    output logic [MACW-1:0]      M_MAC,
    input  logic                 M_VALID,
    input  logic [NETH-1:0]      M_PORT,
`ifdef TBLREQ_ARBITER_TIMEOUT_EN
    output logic                 o_timeout,
`endif
    output logic                 o_busy
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    if (NREQ < 2 || TIMEOUT < 2) begin : g_bad_params
        $error("tblreq_arbiter: NREQ and TIMEOUT must both be at least 2");
    end

    typedef enum logic [1:0] {StIdle, StLookup, StRespond} state_e;

    state_e          state;
    logic [IW-1:0]   last_grant;
    logic [IW-1:0]   grant;
    logic            pick_found;
    logic [IW-1:0]   pick_idx;
    logic [MACW-1:0] pick_mac;
    logic [NREQ-1:0] grant_onehot;

`ifdef TBLREQ_ARBITER_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT);
    logic [CNT_W-1:0] tmo_cnt;
`endif

    // First requesting index at or after last_grant+1, wrapping around.
    always_comb begin
        logic [IW-1:0] cand;
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand = IW'((32'(last_grant) + k) % NREQ);
            if (!pick_found && S_REQUEST[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    assign pick_mac     = S_MAC[pick_idx*MACW +: MACW];
    assign grant_onehot = NREQ'(1) << grant;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state      <= StIdle;
            S_VALID    <= '0;
            S_PORT     <= '0;
            M_REQUEST  <= 1'b0;
            M_MAC      <= '0;
            o_busy     <= 1'b0;
            last_grant <= IW'(NREQ - 1);
            grant      <= '0;
`ifdef TBLREQ_ARBITER_TIMEOUT_EN
            tmo_cnt    <= '0;
            o_timeout  <= 1'b0;
`endif
        end else begin
            S_VALID <= '0;
            case (state)
                StIdle: begin
                    if (pick_found) begin
                        grant      <= pick_idx;
                        last_grant <= pick_idx;
                        M_REQUEST  <= 1'b1;
                        M_MAC      <= pick_mac;
                        o_busy     <= 1'b1;
                        state      <= StLookup;
`ifdef TBLREQ_ARBITER_TIMEOUT_EN
                        tmo_cnt    <= '0;
`endif
                    end
                end
                StLookup: begin
                    // An aborted requester gets no pulse, but the response is still consumed.
                    if (M_VALID) begin
                        S_VALID   <= S_REQUEST[grant] ? grant_onehot : '0;
                        S_PORT    <= M_PORT;
                        M_REQUEST <= 1'b0;
                        state     <= StRespond;
                    end
`ifdef TBLREQ_ARBITER_TIMEOUT_EN
                    else if (tmo_cnt == CNT_W'(TIMEOUT - 1)) begin
                        S_VALID   <= S_REQUEST[grant] ? grant_onehot : '0;
                        S_PORT    <= '1;
                        M_REQUEST <= 1'b0;
                        o_timeout <= 1'b1;
                        state     <= StRespond;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
`endif
                end
                StRespond: begin
                    // No arbitration here: the served requester's request is still high.
                    o_busy <= 1'b0;
                    state  <= StIdle;
                end
                default: begin
                    o_busy <= 1'b0;
                    state  <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tblreq_arbiter.sv
// Directed, table-driven bench for tblreq_arbiter; one row = inputs for one cycle plus the
// registered outputs expected after that cycle's clock edge.
module tb_tblreq_arbiter;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b0;
    logic [3:0]  S_REQUEST = '0;
    logic [191:0] S_MAC;
    logic [3:0]  S_VALID;
    logic [3:0]  S_PORT;
    logic        M_REQUEST;
    logic [47:0] M_MAC;
    logic        M_VALID = 1'b0;
    logic [3:0]  M_PORT = '0;
    logic        o_busy;
`ifdef TBLREQ_ARBITER_TIMEOUT_EN
    logic        o_timeout;
`endif

    logic [47:0] mac [5];

    int checks = 0;
    int errors = 0;

    tblreq_arbiter #(
        .NREQ    (4),
        .NETH    (4),
        .MACW    (48),
        .TIMEOUT (8)
    ) dut (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .S_REQUEST (S_REQUEST),
        .S_MAC     (S_MAC),
        .S_VALID   (S_VALID),
        .S_PORT    (S_PORT),
        .M_REQUEST (M_REQUEST),
        .M_MAC     (M_MAC),
        .M_VALID   (M_VALID),
        .M_PORT    (M_PORT),
`ifdef TBLREQ_ARBITER_TIMEOUT_EN
        .o_timeout (o_timeout),
`endif
        .o_busy    (o_busy)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       mv;
        logic [3:0] mport;
        logic [3:0] sv;
        logic [3:0] port;
        logic       chk_port;
        logic       mreq;
        logic       busy;
        int         mac_idx;   // -1: M_MAC not checked; 4: expect zero
        logic       tmo;
    } vec_t;

    function automatic vec_t mk(input logic rst, input logic [3:0] req, input logic mv,
                                input logic [3:0] mport, input logic [3:0] sv,
                                input logic [3:0] port, input logic chk_port,
                                input logic mreq, input logic busy, input int mac_idx,
                                input logic tmo);
        vec_t r;
        r.rst = rst; r.req = req; r.mv = mv; r.mport = mport; r.sv = sv; r.port = port;
        r.chk_port = chk_port; r.mreq = mreq; r.busy = busy; r.mac_idx = mac_idx; r.tmo = tmo;
        return r;
    endfunction

    task automatic apply_vec(input vec_t v, input string name);
        logic ok;
        logic tmo_got;
        i_reset   = v.rst;
        S_REQUEST = v.req;
        M_VALID   = v.mv;
        M_PORT    = v.mport;
        @(posedge i_clk);
        @(negedge i_clk);
        tmo_got = v.tmo;
`ifdef TBLREQ_ARBITER_TIMEOUT_EN
        tmo_got = o_timeout;
`endif
        ok = (S_VALID === v.sv) && (M_REQUEST === v.mreq) && (o_busy === v.busy)
             && (!v.chk_port || S_PORT === v.port)
             && (v.mac_idx < 0 || M_MAC === mac[v.mac_idx])
             && (tmo_got === v.tmo);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got S_VALID=%b S_PORT=%b M_REQUEST=%b M_MAC=%h o_busy=%b tmo=%b; want S_VALID=%b S_PORT=%b(chk %b) M_REQUEST=%b mac_idx=%0d o_busy=%b tmo=%b",
                     name, S_VALID, S_PORT, M_REQUEST, M_MAC, o_busy, tmo_got,
                     v.sv, v.port, v.chk_port, v.mreq, v.mac_idx, v.busy, v.tmo);
        end
    endtask

    vec_t tbl[$];

    initial begin
        mac[0] = 48'h0A0A_0A0A_0A00;
        mac[1] = 48'h0011_2233_4455;
        mac[2] = 48'hDEAD_BEEF_0002;
        mac[3] = 48'hC0FF_EE00_3333;
        mac[4] = 48'h0;
        S_MAC  = {mac[3], mac[2], mac[1], mac[0]};
        @(negedge i_clk);

        // Reset, then contention: all four at once, table latency 1, requester 0 returns.
        tbl.push_back(mk(1, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 1, 0, 0, 4, 0));
        tbl.push_back(mk(0, 4'b1111, 0, 4'b0000, 4'b0000, 4'b0000, 1, 1, 1, 0, 0));
        tbl.push_back(mk(0, 4'b1111, 1, 4'b0001, 4'b0001, 4'b0001, 1, 0, 1, -1, 0));
        tbl.push_back(mk(0, 4'b1111, 0, 4'b0000, 4'b0000, 4'b0001, 1, 0, 0, -1, 0));
        tbl.push_back(mk(0, 4'b1110, 0, 4'b0000, 4'b0000, 4'b0001, 1, 1, 1, 1, 0));
        tbl.push_back(mk(0, 4'b1110, 1, 4'b0010, 4'b0010, 4'b0010, 1, 0, 1, -1, 0));
        tbl.push_back(mk(0, 4'b1110, 0, 4'b0000, 4'b0000, 4'b0010, 1, 0, 0, -1, 0));
        tbl.push_back(mk(0, 4'b1100, 0, 4'b0000, 4'b0000, 4'b0010, 1, 1, 1, 2, 0));
        tbl.push_back(mk(0, 4'b1101, 1, 4'b0100, 4'b0100, 4'b0100, 1, 0, 1, -1, 0));
        tbl.push_back(mk(0, 4'b1101, 0, 4'b0000, 4'b0000, 4'b0100, 1, 0, 0, -1, 0));
        tbl.push_back(mk(0, 4'b1001, 0, 4'b0000, 4'b0000, 4'b0100, 1, 1, 1, 3, 0));
        tbl.push_back(mk(0, 4'b1001, 1, 4'b1000, 4'b1000, 4'b1000, 1, 0, 1, -1, 0));
        tbl.push_back(mk(0, 4'b1001, 0, 4'b0000, 4'b0000, 4'b1000, 1, 0, 0, -1, 0));
        tbl.push_back(mk(0, 4'b0001, 0, 4'b0000, 4'b0000, 4'b1000, 1, 1, 1, 0, 0));
        tbl.push_back(mk(0, 4'b0001, 1, 4'b0011, 4'b0001, 4'b0011, 1, 0, 1, -1, 0));
        tbl.push_back(mk(0, 4'b0001, 0, 4'b0000, 4'b0000, 4'b0011, 1, 0, 0, -1, 0));
        tbl.push_back(mk(0, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0011, 1, 0, 0, -1, 0));
        // Single lookup by requester 1, table answers two cycles after M_REQUEST.
        tbl.push_back(mk(0, 4'b0010, 0, 4'b0000, 4'b0000, 4'b0011, 1, 1, 1, 1, 0));
        tbl.push_back(mk(0, 4'b0010, 0, 4'b0000, 4'b0000, 4'b0011, 1, 1, 1, 1, 0));
        tbl.push_back(mk(0, 4'b0010, 1, 4'b0100, 4'b0010, 4'b0100, 1, 0, 1, -1, 0));
        tbl.push_back(mk(0, 4'b0010, 0, 4'b0000, 4'b0000, 4'b0100, 1, 0, 0, -1, 0));
        tbl.push_back(mk(0, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0100, 1, 0, 0, -1, 0));
        // Stray M_VALID while idle is ignored; S_PORT holds.
        tbl.push_back(mk(0, 4'b0000, 1, 4'b1111, 4'b0000, 4'b0100, 1, 0, 0, -1, 0));

        foreach (tbl[i]) apply_vec(tbl[i], $sformatf("table[%0d]", i));

        // Back-to-back: requester 2, no double grant in RESPOND, re-request from IDLE.
        apply_vec(mk(0, 4'b0100, 0, 4'b0000, 4'b0000, 4'b0100, 1, 1, 1, 2, 0), "b2b grant");
        apply_vec(mk(0, 4'b0100, 1, 4'b0110, 4'b0100, 4'b0110, 1, 0, 1, -1, 0), "b2b pulse");
        apply_vec(mk(0, 4'b0100, 0, 4'b0000, 4'b0000, 4'b0110, 1, 0, 0, -1, 0), "b2b no regrant");
        apply_vec(mk(0, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0110, 1, 0, 0, -1, 0), "b2b dropped");
        apply_vec(mk(0, 4'b0100, 0, 4'b0000, 4'b0000, 4'b0110, 1, 1, 1, 2, 0), "b2b regrant");
        apply_vec(mk(0, 4'b0100, 1, 4'b1001, 4'b0100, 4'b1001, 1, 0, 1, -1, 0), "b2b pulse2");
        apply_vec(mk(0, 4'b0100, 0, 4'b0000, 4'b0000, 4'b1001, 1, 0, 0, -1, 0), "b2b idle");

        // Abort: requester 3 drops mid-lookup; requester 0 is served next.
        apply_vec(mk(0, 4'b1001, 0, 4'b0000, 4'b0000, 4'b1001, 1, 1, 1, 3, 0), "abort grant3");
        apply_vec(mk(0, 4'b0001, 0, 4'b0000, 4'b0000, 4'b1001, 1, 1, 1, 3, 0), "abort waiting");
        apply_vec(mk(0, 4'b0001, 1, 4'b0001, 4'b0000, 4'b0000, 0, 0, 1, -1, 0), "abort no pulse");
        apply_vec(mk(0, 4'b0001, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, -1, 0), "abort idle");
        apply_vec(mk(0, 4'b0001, 0, 4'b0000, 4'b0000, 4'b0000, 0, 1, 1, 0, 0), "abort next");
        apply_vec(mk(0, 4'b0001, 1, 4'b0101, 4'b0001, 4'b0101, 1, 0, 1, -1, 0), "abort next pulse");
        apply_vec(mk(0, 4'b0001, 0, 4'b0000, 4'b0000, 4'b0101, 1, 0, 0, -1, 0), "abort done");

        // Reset mid-lookup: response ignored, requester 0 regains priority.
        apply_vec(mk(0, 4'b0100, 0, 4'b0000, 4'b0000, 4'b0101, 1, 1, 1, 2, 0), "rst lookup");
        apply_vec(mk(1, 4'b0101, 1, 4'b1110, 4'b0000, 4'b0000, 1, 0, 0, 4, 0), "rst values");
        apply_vec(mk(0, 4'b0101, 0, 4'b0000, 4'b0000, 4'b0000, 1, 1, 1, 0, 0), "rst prio0");
        apply_vec(mk(0, 4'b0101, 1, 4'b1010, 4'b0001, 4'b1010, 1, 0, 1, -1, 0), "rst pulse0");
        apply_vec(mk(0, 4'b0100, 0, 4'b0000, 4'b0000, 4'b1010, 1, 0, 0, -1, 0), "rst respond");
        apply_vec(mk(0, 4'b0000, 0, 4'b0000, 4'b0000, 4'b1010, 1, 0, 0, -1, 0), "rst idle");

`ifdef TBLREQ_ARBITER_TIMEOUT_EN
        // Timeout after 8 LOOKUP cycles: broadcast, sticky flag, late M_VALID ignored.
        apply_vec(mk(0, 4'b0010, 0, 4'b0000, 4'b0000, 4'b1010, 1, 1, 1, 1, 0), "tmo grant");
        for (int i = 0; i < 7; i++)
            apply_vec(mk(0, 4'b0010, 0, 4'b0000, 4'b0000, 4'b1010, 1, 1, 1, 1, 0),
                      $sformatf("tmo wait%0d", i));
        apply_vec(mk(0, 4'b0010, 0, 4'b0000, 4'b0010, 4'b1111, 1, 0, 1, -1, 1), "tmo expire");
        apply_vec(mk(0, 4'b0010, 1, 4'b0000, 4'b0000, 4'b1111, 1, 0, 0, -1, 1), "tmo late mv");
        apply_vec(mk(0, 4'b0000, 1, 4'b0011, 4'b0000, 4'b1111, 1, 0, 0, -1, 1), "tmo sticky");
        apply_vec(mk(1, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 1, 0, 0, 4, 0), "tmo reset");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
